// File: rtl/forward_tx.sv
// Packet forwarder: latches a header, emits dst/my/src/hop+1 then payload words over a valid/ready stream.
// Optional HOP_LIMIT_EN drops packets whose hop count has reached the limit instead of sending them.
module forward_tx (
  input  logic        clock,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] MY_NODE_ID,
  input  logic [15:0] sourceID,
  input  logic [15:0] destinationID,
  input  logic [15:0] hopCount,
  input  logic [3:0]  payloadLen,
  output logic [3:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done,
  output logic        dropped
);

  localparam int unsigned DW = 16;
  localparam int unsigned LW = 4;
  localparam int unsigned IW = 2;
`ifdef HOP_LIMIT_EN
  localparam logic [DW-1:0] HOP_LIMIT = DW'(8);
`endif

  typedef enum logic [2:0] {
    S_WAIT_EN,
    S_IDLE,
    S_LATCH,
    S_HDR,
    S_PAYLOAD,
    S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] my_q, my_d;
  logic [DW-1:0] src_q, src_d;
  logic [DW-1:0] dst_q, dst_d;
  logic [DW-1:0] hop_q, hop_d;
  logic [LW-1:0] len_q, len_d;
  logic [IW-1:0] hdr_idx_q, hdr_idx_d;
  logic [LW-1:0] rd_addr_q, rd_addr_d;
  logic          done_q, done_d;
  logic          tx_valid_q, tx_valid_d;
  logic          drop_q, drop_d;
  logic          xfer;
  logic [DW-1:0] hop_sat;

  assign xfer    = tx_valid_q & tx_ready;
  assign hop_sat = (hop_q == {DW{1'b1}}) ? hop_q : hop_q + DW'(1);

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= S_WAIT_EN;
      my_q       <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      hop_q      <= '0;
      len_q      <= '0;
      hdr_idx_q  <= '0;
      rd_addr_q  <= '0;
      done_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      my_q       <= my_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      hop_q      <= hop_d;
      len_q      <= len_d;
      hdr_idx_q  <= hdr_idx_d;
      rd_addr_q  <= rd_addr_d;
      done_q     <= done_d;
      tx_valid_q <= tx_valid_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state and register updates; all moves in HDR/PAYLOAD happen only on an accepted word.
  always_comb begin
    state_d   = state_q;
    my_d      = my_q;
    src_d     = src_q;
    dst_d     = dst_q;
    hop_d     = hop_q;
    len_d     = len_q;
    hdr_idx_d = hdr_idx_q;
    rd_addr_d = rd_addr_q;
    done_d    = done_q;
    drop_d    = drop_q;
    unique case (state_q)
      S_WAIT_EN: begin
        if (en) begin
          done_d  = 1'b0;
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (start) state_d = S_LATCH;
      end
      S_LATCH: begin
        my_d      = MY_NODE_ID;
        src_d     = sourceID;
        dst_d     = destinationID;
        hop_d     = hopCount;
        len_d     = payloadLen;
        hdr_idx_d = '0;
        rd_addr_d = '0;
        state_d   = S_HDR;
`ifdef HOP_LIMIT_EN
        if (hopCount >= HOP_LIMIT) begin
          drop_d  = 1'b1;
          state_d = S_FIN;
        end
`endif
      end
      S_HDR: begin
        if (xfer) begin
          hdr_idx_d = hdr_idx_q + IW'(1);
          if (hdr_idx_q == IW'(3)) begin
            rd_addr_d = '0;
            state_d   = (len_q == '0) ? S_FIN : S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          rd_addr_d = rd_addr_q + LW'(1);
          if (rd_addr_q == len_q - LW'(1)) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_WAIT_EN;
      end
      default: state_d = S_WAIT_EN;
    endcase
    if (state_d == S_FIN) done_d = 1'b1;
    tx_valid_d = (state_d == S_HDR) || (state_d == S_PAYLOAD);
  end

  // Word mux: header words come from latched fields, payload passes the buffer read straight through.
  always_comb begin
    tx_data = '0;
    if (state_q == S_PAYLOAD) begin
      tx_data = rd_data;
    end else if (state_q == S_HDR) begin
      unique case (hdr_idx_q)
        2'd0:    tx_data = dst_q;
        2'd1:    tx_data = my_q;
        2'd2:    tx_data = src_q;
        default: tx_data = hop_sat;
      endcase
    end
  end

  assign rd_addr  = rd_addr_q;
  assign tx_valid = tx_valid_q;
  assign done     = done_q;
`ifdef HOP_LIMIT_EN
  assign dropped  = drop_q;
`else
  assign dropped  = 1'b0;
`endif

endmodule
